// File: rtl/sb_mem_slave.sv
// SB bus memory-backed burst slave: header accept, write/read bursts, one-cycle response.
// Optional mid-burst abort on sb_sel deassertion when SB_SLAVE_ABORT_EN is defined.
module sb_mem_slave #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MEM_DEPTH  = 2048
) (
   input  logic                  sb_clk,
   input  logic                  sb_resetn,
   input  logic                  sb_sel,
   input  logic                  sb_start,
   input  logic                  sb_write,
   input  logic [31:0]           sb_addr,
   input  logic [2:0]            sb_size,
   input  logic [DATA_WIDTH-1:0] sb_wdata,
   input  logic                  sb_wvalid,
   input  logic                  sb_rready,
   output logic                  sb_ready,
   output logic [DATA_WIDTH-1:0] sb_rdata,
   output logic                  sb_rvalid,
   output logic                  sb_done,
   output logic [1:0]            sb_resp
);

   localparam int unsigned OFS_W = $clog2(MEM_DEPTH);
   localparam int unsigned CNT_W = 6;

   typedef enum logic [1:0] {StIdle, StWrite, StRead, StResp} state_e;

   state_e                state_q, state_d;
   logic [OFS_W-1:0]      addr_q, addr_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [CNT_W-1:0]      nbeat_q, nbeat_d;
   logic                  err_q, err_d;
   logic                  ready_q;
   logic                  rvalid_q, rvalid_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  mem_we;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   logic                  accept;
   logic                  abort;
   logic                  size_err;
   logic                  bound_err;
   logic [CNT_W-1:0]      hdr_nbeat;
   logic [OFS_W:0]        hdr_last;
   logic                  unused_addr;

   assign unused_addr = ^sb_addr[31:OFS_W];
   assign accept      = ready_q & sb_sel & sb_start;

`ifdef SB_SLAVE_ABORT_EN
   assign abort = ~sb_sel;
`else
   assign abort = 1'b0;
`endif

   // One extra bit catches bursts that would run past the last word.
   always_comb begin
      hdr_nbeat = CNT_W'(1);
      size_err  = 1'b1;
      if (sb_size >= 3'b010) begin
         hdr_nbeat = CNT_W'(1) << (sb_size - 3'b010);
         size_err  = 1'b0;
      end
      hdr_last  = {1'b0, sb_addr[OFS_W-1:0]} + (OFS_W+1)'(hdr_nbeat) - (OFS_W+1)'(1);
      bound_err = hdr_last[OFS_W];
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      cnt_d    = cnt_q;
      nbeat_d  = nbeat_q;
      err_d    = err_q;
      rdata_d  = rdata_q;
      rvalid_d = rvalid_q;
      mem_we   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               addr_d  = sb_addr[OFS_W-1:0];
               nbeat_d = hdr_nbeat;
               cnt_d   = '0;
               err_d   = size_err | bound_err;
               if (size_err | bound_err) begin
                  state_d = StResp;
               end else if (sb_write) begin
                  state_d = StWrite;
               end else begin
                  state_d = StRead;
               end
            end
         end
         StWrite: begin
            if (abort) begin
               err_d   = 1'b1;
               state_d = StResp;
            end else if (sb_wvalid) begin
               mem_we = 1'b1;
               addr_d = addr_q + OFS_W'(1);
               cnt_d  = cnt_q + CNT_W'(1);
               if (cnt_q == nbeat_q - CNT_W'(1)) begin
                  state_d = StResp;
               end
            end
         end
         StRead: begin
            if (abort) begin
               err_d    = 1'b1;
               rvalid_d = 1'b0;
               state_d  = StResp;
            end else if (rvalid_q && sb_rready && (cnt_q == nbeat_q)) begin
               rvalid_d = 1'b0;
               state_d  = StResp;
            end else if ((!rvalid_q || sb_rready) && (cnt_q != nbeat_q)) begin
               // Output register is empty or being drained: load the next word.
               rdata_d  = mem[addr_q];
               rvalid_d = 1'b1;
               addr_d   = addr_q + OFS_W'(1);
               cnt_d    = cnt_q + CNT_W'(1);
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge sb_clk or negedge sb_resetn) begin
      if (!sb_resetn) begin
         state_q  <= StIdle;
         addr_q   <= '0;
         cnt_q    <= '0;
         nbeat_q  <= '0;
         err_q    <= 1'b0;
         ready_q  <= 1'b0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         cnt_q    <= cnt_d;
         nbeat_q  <= nbeat_d;
         err_q    <= err_d;
         ready_q  <= (state_d == StIdle);
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
      end
   end

   always_ff @(posedge sb_clk) begin
      if (mem_we) begin
         mem[addr_q] <= sb_wdata;
      end
   end

   assign sb_ready  = ready_q;
   assign sb_rdata  = rdata_q;
   assign sb_rvalid = rvalid_q;
   assign sb_done   = (state_q == StResp);
   assign sb_resp   = ((state_q == StResp) && err_q) ? 2'b10 : 2'b00;

endmodule

// File: tb/tb_sb_mem_slave.sv
// Directed, table-driven bench for sb_mem_slave with a reference word array.
// Abort expectations follow SB_SLAVE_ABORT_EN, matching the DUT build.
module tb_sb_mem_slave;

   logic        sb_clk;
   logic        sb_resetn;
   logic        sb_sel;
   logic        sb_start;
   logic        sb_write;
   logic [31:0] sb_addr;
   logic [2:0]  sb_size;
   logic [31:0] sb_wdata;
   logic        sb_wvalid;
   logic        sb_rready;
   logic        sb_ready;
   logic [31:0] sb_rdata;
   logic        sb_rvalid;
   logic        sb_done;
   logic [1:0]  sb_resp;

   int unsigned n_cmp;
   int unsigned n_err;
   logic [31:0] mdl [0:2047];

   typedef struct {
      bit          wr;
      int unsigned ofs;
      logic [2:0]  size;
      logic [31:0] base;
      bit          gap;
      bit          noisy;
      bit          err;
   } vec_t;

   vec_t vecs[$];

   sb_mem_slave dut (
      .sb_clk    (sb_clk),
      .sb_resetn (sb_resetn),
      .sb_sel    (sb_sel),
      .sb_start  (sb_start),
      .sb_write  (sb_write),
      .sb_addr   (sb_addr),
      .sb_size   (sb_size),
      .sb_wdata  (sb_wdata),
      .sb_wvalid (sb_wvalid),
      .sb_rready (sb_rready),
      .sb_ready  (sb_ready),
      .sb_rdata  (sb_rdata),
      .sb_rvalid (sb_rvalid),
      .sb_done   (sb_done),
      .sb_resp   (sb_resp)
   );

   initial sb_clk = 1'b0;
   always #5 sb_clk = ~sb_clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge sb_clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int unsigned nb_of(input logic [2:0] s);
      return (s >= 3'd2) ? (32'd1 << (s - 3'd2)) : 32'd0;
   endfunction

   task automatic do_write(input int unsigned ofs, input logic [2:0] size, input logic [31:0] base,
                           input bit gap, input bit noisy, input bit err);
      int unsigned nb;
      nb       = nb_of(size);
      sb_sel   = 1'b1;
      sb_start = 1'b1;
      sb_write = 1'b1;
      sb_addr  = 32'hABC0_0000 | ofs;
      sb_size  = size;
      tick();
      sb_start = 1'b0;
      check("wr_hdr_ready_low", {63'd0, sb_ready}, 64'd0);
      if (err) begin
         check("wr_err_done", {63'd0, sb_done}, 64'd1);
         check("wr_err_resp", {62'd0, sb_resp}, 64'd2);
         tick();
         check("wr_err_ready_back", {63'd0, sb_ready}, 64'd1);
         return;
      end
      for (int b = 0; b < int'(nb); b++) begin
         if (gap && (b % 2 == 1)) begin
            sb_wvalid = 1'b0;
            sb_wdata  = 32'hDEAD_BEEF;
            tick();
         end
         sb_wdata  = base + 32'(b);
         sb_wvalid = 1'b1;
         if (noisy && (b != int'(nb) - 1)) begin
            sb_start = 1'b1;
            sb_write = 1'b0;
            sb_addr  = 32'h0000_0000;
            sb_size  = 3'b001;
         end else begin
            sb_start = 1'b0;
         end
         tick();
         if (b != int'(nb) - 1) check("wr_busy_no_done", {63'd0, sb_done}, 64'd0);
      end
      sb_wvalid = 1'b0;
      sb_start  = 1'b0;
      check("wr_done", {63'd0, sb_done}, 64'd1);
      check("wr_resp_okay", {62'd0, sb_resp}, 64'd0);
      for (int b = 0; b < int'(nb); b++) mdl[ofs + b] = base + 32'(b);
      tick();
      check("wr_ready_back", {63'd0, sb_ready}, 64'd1);
      check("wr_done_one_cycle", {63'd0, sb_done}, 64'd0);
   endtask

   task automatic do_read(input int unsigned ofs, input logic [2:0] size, input bit err,
                          input bit bp);
      int unsigned nb;
      int unsigned beats;
      bit          hold;
      bit          fin;
      logic [31:0] held;
      nb        = nb_of(size);
      sb_sel    = 1'b1;
      sb_start  = 1'b1;
      sb_write  = 1'b0;
      sb_addr   = 32'hABC0_0000 | ofs;
      sb_size   = size;
      sb_rready = 1'b0;
      tick();
      sb_start = 1'b0;
      check("rd_hdr_ready_low", {63'd0, sb_ready}, 64'd0);
      if (err) begin
         check("rd_err_done", {63'd0, sb_done}, 64'd1);
         check("rd_err_resp", {62'd0, sb_resp}, 64'd2);
         check("rd_err_no_rvalid", {63'd0, sb_rvalid}, 64'd0);
         tick();
         check("rd_err_ready_back", {63'd0, sb_ready}, 64'd1);
         check("rd_err_no_rvalid2", {63'd0, sb_rvalid}, 64'd0);
         return;
      end
      beats = 0;
      hold  = 1'b0;
      fin   = 1'b0;
      held  = '0;
      for (int c = 0; c < 400 && !fin; c++) begin
         sb_rready = bp ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
         if (c == 0) check("rd_lat_cycle0", {63'd0, sb_rvalid}, 64'd0);
         if (c == 1) check("rd_lat_cycle1", {63'd0, sb_rvalid}, 64'd1);
         if (hold) begin
            check("rd_hold_valid", {63'd0, sb_rvalid}, 64'd1);
            check("rd_hold_data", {32'd0, sb_rdata}, {32'd0, held});
         end
         if (sb_done) begin
            fin = 1'b1;
            check("rd_resp_okay", {62'd0, sb_resp}, 64'd0);
            check("rd_done_no_rvalid", {63'd0, sb_rvalid}, 64'd0);
         end else begin
            if (sb_rvalid && sb_rready) begin
               check("rd_beat_data", {32'd0, sb_rdata},
                     (beats < nb) ? {32'd0, mdl[ofs + beats]} : 64'hFFFF_FFFF_FFFF_FFFF);
               beats++;
            end
            hold = sb_rvalid && !sb_rready;
            held = sb_rdata;
            tick();
         end
      end
      check("rd_done_seen", {63'd0, fin}, 64'd1);
      check("rd_handshakes", 64'(beats), 64'(nb));
      sb_rready = 1'b0;
      tick();
      check("rd_ready_back", {63'd0, sb_ready}, 64'd1);
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      sb_resetn = 1'b0;
      sb_sel    = 1'b0;
      sb_start  = 1'b0;
      sb_write  = 1'b0;
      sb_addr   = '0;
      sb_size   = '0;
      sb_wdata  = '0;
      sb_wvalid = 1'b0;
      sb_rready = 1'b0;

      //         wr    ofs    size    base          gap   noisy err
      vecs.push_back('{1'b1, 32'h10,  3'b100, 32'h0000_00A0, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 32'h10,  3'b100, 32'h0,         1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 32'h40,  3'b101, 32'h0000_0050, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 2040,    3'b101, 32'h0000_00B0, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 2041,    3'b101, 32'h0000_00C0, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{1'b0, 2040,    3'b101, 32'h0,         1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 32'h20,  3'b001, 32'h0000_0077, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{1'b0, 2041,    3'b101, 32'h0,         1'b0, 1'b0, 1'b1});
      vecs.push_back('{1'b0, 32'h20,  3'b000, 32'h0,         1'b0, 1'b0, 1'b1});
      vecs.push_back('{1'b1, 32'h0,   3'b010, 32'h0000_0011, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 32'h0,   3'b010, 32'h0,         1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 32'h100, 3'b111, 32'h0000_0300, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 32'h100, 3'b111, 32'h0,         1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 32'h30,  3'b100, 32'h0000_03C0, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 32'h30,  3'b100, 32'h0,         1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 2047,    3'b010, 32'h0000_00EE, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 2047,    3'b011, 32'h0,         1'b0, 1'b0, 1'b1});
      vecs.push_back('{1'b0, 2047,    3'b010, 32'h0,         1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 32'h400, 3'b100, 32'h0000_05A0, 1'b0, 1'b0, 1'b0});

      // Reset state and release.
      tick();
      tick();
      check("rst_ready", {63'd0, sb_ready}, 64'd0);
      check("rst_rvalid", {63'd0, sb_rvalid}, 64'd0);
      check("rst_rdata", {32'd0, sb_rdata}, 64'd0);
      check("rst_done", {63'd0, sb_done}, 64'd0);
      check("rst_resp", {62'd0, sb_resp}, 64'd0);
      sb_resetn = 1'b1;
      #1;
      check("rel_ready_still_low", {63'd0, sb_ready}, 64'd0);
      tick();
      check("rel_ready_high", {63'd0, sb_ready}, 64'd1);

      foreach (vecs[i]) begin
         if (vecs[i].wr) begin
            do_write(vecs[i].ofs, vecs[i].size, vecs[i].base, vecs[i].gap, vecs[i].noisy,
                     vecs[i].err);
         end else begin
            do_read(vecs[i].ofs, vecs[i].size, vecs[i].err, 1'b0);
         end
      end

      // Backpressured 8-beat read, rready pattern 1,0,0,1.
      do_read(32'h40, 3'b101, 1'b0, 1'b1);

      // Header without select is ignored.
      sb_sel   = 1'b0;
      sb_start = 1'b1;
      sb_write = 1'b1;
      sb_size  = 3'b100;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("nosel_ready", {63'd0, sb_ready}, 64'd1);
         check("nosel_done", {63'd0, sb_done}, 64'd0);
      end
      sb_start = 1'b0;

      // Drop select after two beats of a 16-beat write.
      sb_sel   = 1'b1;
      sb_start = 1'b1;
      sb_write = 1'b1;
      sb_addr  = 32'h0000_0400;
      sb_size  = 3'b110;
      tick();
      sb_start = 1'b0;
      for (int b = 0; b < 16; b++) begin
         sb_sel    = (b < 2);
         sb_wdata  = 32'h900 + 32'(b);
         sb_wvalid = 1'b1;
         tick();
`ifdef SB_SLAVE_ABORT_EN
         if (b == 2) begin
            check("abort_done", {63'd0, sb_done}, 64'd1);
            check("abort_resp", {62'd0, sb_resp}, 64'd2);
            break;
         end
`endif
      end
      sb_wvalid = 1'b0;
      sb_sel    = 1'b1;
`ifdef SB_SLAVE_ABORT_EN
      for (int b = 0; b < 2; b++) mdl[32'h400 + b] = 32'h900 + 32'(b);
`else
      check("noabort_done", {63'd0, sb_done}, 64'd1);
      check("noabort_resp", {62'd0, sb_resp}, 64'd0);
      for (int b = 0; b < 16; b++) mdl[32'h400 + b] = 32'h900 + 32'(b);
`endif
      tick();
      check("abort_ready_back", {63'd0, sb_ready}, 64'd1);
      do_read(32'h400, 3'b100, 1'b0, 1'b0);

      // Reset in the middle of a write: no done, written beats stay.
      sb_sel   = 1'b1;
      sb_start = 1'b1;
      sb_write = 1'b1;
      sb_addr  = 32'h0000_0200;
      sb_size  = 3'b110;
      tick();
      sb_start = 1'b0;
      for (int b = 0; b < 5; b++) begin
         sb_wdata  = 32'h700 + 32'(b);
         sb_wvalid = 1'b1;
         tick();
      end
      sb_wvalid = 1'b0;
      for (int b = 0; b < 5; b++) mdl[32'h200 + b] = 32'h700 + 32'(b);
      #2;
      sb_resetn = 1'b0;
      #1;
      check("midwr_rst_done", {63'd0, sb_done}, 64'd0);
      check("midwr_rst_ready", {63'd0, sb_ready}, 64'd0);
      tick();
      check("midwr_rst_no_done", {63'd0, sb_done}, 64'd0);
      sb_resetn = 1'b1;
      tick();
      check("midwr_rel_ready", {63'd0, sb_ready}, 64'd1);
      do_read(32'h200, 3'b100, 1'b0, 1'b0);

      // Reset while a read beat is held under backpressure.
      sb_sel    = 1'b1;
      sb_start  = 1'b1;
      sb_write  = 1'b0;
      sb_addr   = 32'h0000_0010;
      sb_size   = 3'b100;
      sb_rready = 1'b0;
      tick();
      sb_start = 1'b0;
      tick();
      tick();
      check("midrd_rvalid", {63'd0, sb_rvalid}, 64'd1);
      check("midrd_rdata", {32'd0, sb_rdata}, 64'h0000_00A0);
      #2;
      sb_resetn = 1'b0;
      #1;
      check("midrd_rst_rvalid", {63'd0, sb_rvalid}, 64'd0);
      check("midrd_rst_rdata", {32'd0, sb_rdata}, 64'd0);
      check("midrd_rst_done", {63'd0, sb_done}, 64'd0);
      check("midrd_rst_ready", {63'd0, sb_ready}, 64'd0);
      tick();
      sb_resetn = 1'b1;
      tick();
      check("midrd_rel_ready", {63'd0, sb_ready}, 64'd1);
      do_read(32'h10, 3'b100, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
